// File: rtl/tmds_pkg.sv
// Shared TMDS receive definitions: control tokens, guard codes, TERC4 table,
// period/alignment enums and the video-symbol decode helper.
package tmds_pkg;

   localparam logic [9:0] CTRL_TOK_00    = 10'b1101010100;
   localparam logic [9:0] CTRL_TOK_01    = 10'b0010101011;
   localparam logic [9:0] CTRL_TOK_10    = 10'b0101010100;
   localparam logic [9:0] CTRL_TOK_11    = 10'b1010101011;

   localparam logic [9:0] VID_GUARD_CH02 = 10'b1011001100;
   localparam logic [9:0] VID_GUARD_CH1  = 10'b0100110011;
   localparam logic [9:0] ISL_GUARD_CH12 = 10'b0100110011;

   typedef enum logic [1:0] {
      PER_CTRL   = 2'd0,
      PER_VIDEO  = 2'd1,
      PER_ISLAND = 2'd2,
      PER_GUARD  = 2'd3
   } period_e;

   typedef enum logic [1:0] {
      AL_SEARCH = 2'd0,
      AL_SLIP   = 2'd1,
      AL_SETTLE = 2'd2,
      AL_LOCKED = 2'd3
   } align_e;

   // Per-symbol classification carried from stage 1 to stage 2.
   typedef struct packed {
      logic       tok;
      logic [1:0] tok_bits;
      logic       t4_hit;
      logic [3:0] t4_nib;
      logic       vguard;
      logic       iguard;
   } sym_class_t;

   // 16-entry TERC4 code table, nibble -> 10-bit symbol.
   function automatic logic [9:0] terc4_code(input logic [3:0] nib);
      logic [9:0] c;
      case (nib)
         4'h0:    c = 10'b1010011100;
         4'h1:    c = 10'b1001100011;
         4'h2:    c = 10'b1011100100;
         4'h3:    c = 10'b1011100010;
         4'h4:    c = 10'b0101110001;
         4'h5:    c = 10'b0100011110;
         4'h6:    c = 10'b0110001110;
         4'h7:    c = 10'b0100111100;
         4'h8:    c = 10'b1011001100;
         4'h9:    c = 10'b0100111001;
         4'hA:    c = 10'b0110011100;
         4'hB:    c = 10'b1011000110;
         4'hC:    c = 10'b1010001110;
         4'hD:    c = 10'b1001110001;
         4'hE:    c = 10'b0101100011;
         4'hF:    c = 10'b1011000011;
         default: c = 10'b0000000000;
      endcase
      return c;
   endfunction

   // TMDS video decode: undo optional inversion, then the XOR/XNOR chain.
   function automatic logic [7:0] video_decode(input logic [9:0] q);
      logic [7:0] v;
      logic [7:0] d;
      v    = q[9] ? ~q[7:0] : q[7:0];
      d[0] = v[0];
      for (int i = 1; i < 8; i++) begin
         d[i] = q[8] ? (v[i] ^ v[i-1]) : ~(v[i] ^ v[i-1]);
      end
      return d;
   endfunction

endpackage

// File: rtl/tmds_channel_decoder_if.sv
// Symbol input and decoded outputs of one TMDS channel decoder.
interface tmds_channel_decoder_if;
   logic [9:0] sym_in;
   logic       bitslip;
   logic [3:0] slip_count;
   logic       locked;
   logic [1:0] period;
   logic       de;
   logic [7:0] data;
   logic [1:0] ctrl;
   logic       terc4_valid;
   logic [3:0] terc4;
   logic       sym_err;

   // Deserialiser / consumer side.
   modport master (output sym_in,
                   input  bitslip, slip_count, locked, period, de, data,
                          ctrl, terc4_valid, terc4, sym_err);
   // Decoder side.
   modport slave  (input  sym_in,
                   output bitslip, slip_count, locked, period, de, data,
                          ctrl, terc4_valid, terc4, sym_err);
endinterface

// File: rtl/tmds_terc4_decode.sv
// Combinational TERC4 lookup: 10-bit symbol -> {hit, nibble}.
module tmds_terc4_decode
   import tmds_pkg::*;
(
   input  logic [9:0] sym_i,
   output logic       hit_o,
   output logic [3:0] nib_o
);

   // Compare the symbol against every table entry; codes are unique.
   always_comb begin
      hit_o = 1'b0;
      nib_o = 4'h0;
      for (int i = 0; i < 16; i++) begin
         if (sym_i == terc4_code(4'(i))) begin
            hit_o = 1'b1;
            nib_o = 4'(i);
         end else begin
            hit_o = hit_o;
            nib_o = nib_o;
         end
      end
   end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: word alignment via bitslip, HDMI period tracking,
// video / control / TERC4 decode. Two-stage pipeline, all outputs registered.
module tmds_channel_decoder
   import tmds_pkg::*;
#(
   parameter int CHANNEL       = 0,
   parameter int CTRL_RUN      = 8,
   parameter int SEARCH_CYCLES = 2048,
   parameter int SLIP_SETTLE   = 4,
   parameter int LOSS_CYCLES   = 4096
)(
   input  logic                  clk,
   input  logic                  rst_n,
   tmds_channel_decoder_if.slave bus
);

   localparam int RW = $clog2(CTRL_RUN + 1);
   localparam int TW = $clog2(SEARCH_CYCLES + 1);
   localparam int SW = $clog2(SLIP_SETTLE + 1);
   localparam int WW = $clog2(LOSS_CYCLES + 1);
   localparam logic [9:0] VGUARD = (CHANNEL == 1) ? VID_GUARD_CH1 : VID_GUARD_CH02;

   logic          t4_hit_s;
   logic [3:0]    t4_nib_s;
   sym_class_t    cls_d;
   sym_class_t    cls_q;
   logic [9:0]    sym_q;

   align_e        align_q;
   logic [RW-1:0] run_q;
   logic [TW-1:0] timer_q;
   logic [SW-1:0] settle_q;
   logic [WW-1:0] wd_q;
   logic          bitslip_q, locked_q;
   logic [3:0]    slip_count_q;

   period_e       per_q, period_q;
   logic          g_second_q, g_trail_q, may_vid_q, may_isl_q, isl_seen_q;
   logic          de_q, tv_q, err_q;
   logic [7:0]    data_q;
   logic [1:0]    ctrl_q;
   logic [3:0]    t4_q;

   logic          wd_expire_s, run_lock_s, proc_s;

   tmds_terc4_decode u_terc4 (
      .sym_i (bus.sym_in),
      .hit_o (t4_hit_s),
      .nib_o (t4_nib_s)
   );

   // Stage-1 classification of the incoming raw symbol.
   always_comb begin
      cls_d        = '0;
      case (bus.sym_in)
         CTRL_TOK_00: begin cls_d.tok = 1'b1; cls_d.tok_bits = 2'b00; end
         CTRL_TOK_01: begin cls_d.tok = 1'b1; cls_d.tok_bits = 2'b01; end
         CTRL_TOK_10: begin cls_d.tok = 1'b1; cls_d.tok_bits = 2'b10; end
         CTRL_TOK_11: begin cls_d.tok = 1'b1; cls_d.tok_bits = 2'b11; end
         default:     cls_d.tok = 1'b0;
      endcase
      cls_d.t4_hit = t4_hit_s;
      cls_d.t4_nib = t4_nib_s;
      cls_d.vguard = (bus.sym_in == VGUARD);
      // Channel 0 has no dedicated island guard; TERC4 0xC..0xF plays that role.
      if (CHANNEL == 0) begin
         cls_d.iguard = t4_hit_s && (t4_nib_s[3:2] == 2'b11);
      end else begin
         cls_d.iguard = (bus.sym_in == ISL_GUARD_CH12);
      end
   end

   // Stage-1 register: raw symbol plus its classification.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sym_q <= 10'd0;
         cls_q <= '0;
      end else begin
         sym_q <= bus.sym_in;
         cls_q <= cls_d;
      end
   end

   // Stage-2 helper conditions shared by both FSMs; a token beats watchdog expiry.
   always_comb begin
      wd_expire_s = (align_q == AL_LOCKED) && !cls_q.tok && (wd_q == WW'(LOSS_CYCLES - 1));
      run_lock_s  = cls_q.tok && (run_q == RW'(CTRL_RUN - 1));
      proc_s      = (align_q == AL_LOCKED) && !wd_expire_s;
   end

   // Alignment FSM: search for a control-token run, bitslip on timeout, watchdog when locked.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         align_q      <= AL_SEARCH;
         run_q        <= '0;
         timer_q      <= '0;
         settle_q     <= '0;
         wd_q         <= '0;
         bitslip_q    <= 1'b0;
         locked_q     <= 1'b0;
         slip_count_q <= 4'd0;
      end else begin
         case (align_q)
            AL_SEARCH: begin
               bitslip_q <= 1'b0;
               if (run_lock_s) begin
                  align_q  <= AL_LOCKED;
                  locked_q <= 1'b1;
                  run_q    <= '0;
                  timer_q  <= '0;
                  wd_q     <= '0;
               end else if (timer_q == TW'(SEARCH_CYCLES - 1)) begin
                  align_q      <= AL_SLIP;
                  bitslip_q    <= 1'b1;
                  slip_count_q <= (slip_count_q == 4'd9) ? 4'd0 : slip_count_q + 4'd1;
                  timer_q      <= '0;
                  run_q        <= '0;
               end else begin
                  timer_q <= timer_q + TW'(1);
                  run_q   <= cls_q.tok ? run_q + RW'(1) : RW'(0);
               end
            end
            AL_SLIP: begin
               bitslip_q <= 1'b0;
               settle_q  <= '0;
               align_q   <= AL_SETTLE;
            end
            AL_SETTLE: begin
               if (settle_q == SW'(SLIP_SETTLE - 1)) begin
                  align_q  <= AL_SEARCH;
                  settle_q <= '0;
                  timer_q  <= '0;
                  run_q    <= '0;
               end else begin
                  settle_q <= settle_q + SW'(1);
               end
            end
            AL_LOCKED: begin
               bitslip_q <= 1'b0;
               if (cls_q.tok) begin
                  wd_q <= '0;
               end else if (wd_expire_s) begin
                  align_q  <= AL_SEARCH;
                  locked_q <= 1'b0;
                  wd_q     <= '0;
                  timer_q  <= '0;
                  run_q    <= '0;
               end else begin
                  wd_q <= wd_q + WW'(1);
               end
            end
            default: begin
               align_q   <= AL_SEARCH;
               bitslip_q <= 1'b0;
               locked_q  <= 1'b0;
            end
         endcase
      end
   end

   // Period FSM and registered decode outputs; held at CTRL unless locked.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         per_q      <= PER_CTRL;
         period_q   <= PER_CTRL;
         g_second_q <= 1'b0;
         g_trail_q  <= 1'b0;
         may_vid_q  <= 1'b0;
         may_isl_q  <= 1'b0;
         isl_seen_q <= 1'b0;
         de_q       <= 1'b0;
         data_q     <= 8'h00;
         ctrl_q     <= 2'b00;
         tv_q       <= 1'b0;
         t4_q       <= 4'h0;
         err_q      <= 1'b0;
      end else begin
         period_q <= PER_CTRL;
         de_q     <= 1'b0;
         data_q   <= 8'h00;
         ctrl_q   <= 2'b00;
         tv_q     <= 1'b0;
         t4_q     <= 4'h0;
         err_q    <= 1'b0;
         if (!proc_s) begin
            per_q <= PER_CTRL;
            if (cls_q.tok) ctrl_q <= cls_q.tok_bits;
         end else if (cls_q.tok) begin
            // A control token always returns to CTRL from any period.
            per_q  <= PER_CTRL;
            ctrl_q <= cls_q.tok_bits;
         end else begin
            case (per_q)
               PER_CTRL: begin
                  if (cls_q.vguard || cls_q.iguard) begin
                     per_q      <= PER_GUARD;
                     period_q   <= PER_GUARD;
                     g_second_q <= 1'b0;
                     g_trail_q  <= 1'b0;
                     may_vid_q  <= cls_q.vguard;
                     may_isl_q  <= cls_q.iguard;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
               PER_GUARD: begin
                  if (!g_second_q) begin
                     if ((may_vid_q && cls_q.vguard) || (may_isl_q && cls_q.iguard)) begin
                        period_q   <= PER_GUARD;
                        g_second_q <= 1'b1;
                        per_q      <= g_trail_q ? PER_CTRL : PER_GUARD;
                     end else begin
                        err_q <= 1'b1;
                        per_q <= PER_CTRL;
                     end
                  end else if (may_isl_q && cls_q.t4_hit) begin
                     // Ambiguous guard (ch1): a TERC4 payload selects the island.
                     per_q      <= PER_ISLAND;
                     period_q   <= PER_ISLAND;
                     tv_q       <= 1'b1;
                     t4_q       <= cls_q.t4_nib;
                     isl_seen_q <= 1'b1;
                  end else if (may_vid_q) begin
                     per_q    <= PER_VIDEO;
                     period_q <= PER_VIDEO;
                     de_q     <= 1'b1;
                     data_q   <= video_decode(sym_q);
                  end else begin
                     per_q      <= PER_ISLAND;
                     period_q   <= PER_ISLAND;
                     err_q      <= 1'b1;
                     isl_seen_q <= 1'b0;
                  end
               end
               PER_VIDEO: begin
                  period_q <= PER_VIDEO;
                  de_q     <= 1'b1;
                  data_q   <= video_decode(sym_q);
               end
               PER_ISLAND: begin
                  period_q <= PER_ISLAND;
                  if ((CHANNEL != 0) && cls_q.iguard && isl_seen_q) begin
                     per_q      <= PER_GUARD;
                     period_q   <= PER_GUARD;
                     g_second_q <= 1'b0;
                     g_trail_q  <= 1'b1;
                     may_vid_q  <= 1'b0;
                     may_isl_q  <= 1'b1;
                  end else if (cls_q.t4_hit) begin
                     tv_q       <= 1'b1;
                     t4_q       <= cls_q.t4_nib;
                     isl_seen_q <= 1'b1;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
               default: per_q <= PER_CTRL;
            endcase
         end
      end
   end

   assign bus.bitslip     = bitslip_q;
   assign bus.slip_count  = slip_count_q;
   assign bus.locked      = locked_q;
   assign bus.period      = period_q;
   assign bus.de          = de_q;
   assign bus.data        = data_q;
   assign bus.ctrl        = ctrl_q;
   assign bus.terc4_valid = tv_q;
   assign bus.terc4       = t4_q;
   assign bus.sym_err     = err_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed, table-driven bench for tmds_channel_decoder (channel 0 and channel 1 instances).
module tb_tmds_channel_decoder;

   localparam int CTRL_RUN      = 8;
   localparam int SEARCH_CYCLES = 2048;
   localparam int SLIP_SETTLE   = 4;
   localparam int LOSS_CYCLES   = 4096;

   localparam logic [9:0] TOK00 = 10'h354;
   localparam logic [9:0] TOK01 = 10'h0AB;
   localparam logic [9:0] TOK10 = 10'h154;
   localparam logic [9:0] TOK11 = 10'h2AB;
   localparam logic [9:0] VG0   = 10'h2CC;
   localparam logic [9:0] GD1   = 10'h133;

   typedef struct {
      logic [9:0] sym;
      logic [1:0] per;
      logic       de;
      logic [7:0] data;
      logic [1:0] ctrl;
      logic       tv;
      logic [3:0] t4;
      logic       err;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   int   slip_seen = 0;
   vec_t v0[$];
   vec_t v1[$];

   tmds_channel_decoder_if bus0();
   tmds_channel_decoder_if bus1();

   tmds_channel_decoder #(.CHANNEL(0), .CTRL_RUN(CTRL_RUN), .SEARCH_CYCLES(SEARCH_CYCLES),
                          .SLIP_SETTLE(SLIP_SETTLE), .LOSS_CYCLES(LOSS_CYCLES))
      dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   tmds_channel_decoder #(.CHANNEL(1), .CTRL_RUN(CTRL_RUN), .SEARCH_CYCLES(SEARCH_CYCLES),
                          .SLIP_SETTLE(SLIP_SETTLE), .LOSS_CYCLES(LOSS_CYCLES))
      dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   always #5 clk = ~clk;

   // Count channel-0 bitslip pulses on the falling edge.
   always @(negedge clk) begin
      if (rst_n && bus0.bitslip) slip_seen++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [9:0] s, input logic [1:0] p, input logic de,
                               input logic [7:0] d, input logic [1:0] c, input logic tv,
                               input logic [3:0] t, input logic e);
      vec_t v;
      v.sym = s; v.per = p; v.de = de; v.data = d; v.ctrl = c; v.tv = tv; v.t4 = t; v.err = e;
      return v;
   endfunction

   function automatic logic [9:0] rotl(input logic [9:0] x, input int k);
      logic [9:0] r;
      r = x;
      for (int i = 0; i < k; i++) r = {r[8:0], r[9]};
      return r;
   endfunction

   function automatic logic [31:0] outs0();
      return {13'd0, bus0.period, bus0.de, bus0.data, bus0.ctrl, bus0.terc4_valid, bus0.terc4, bus0.sym_err};
   endfunction

   function automatic logic [31:0] outs1();
      return {13'd0, bus1.period, bus1.de, bus1.data, bus1.ctrl, bus1.terc4_valid, bus1.terc4, bus1.sym_err};
   endfunction

   function automatic logic [31:0] packv(input vec_t v);
      return {13'd0, v.per, v.de, v.data, v.ctrl, v.tv, v.t4, v.err};
   endfunction

   // Apply a vector table on one channel; outputs for row i appear two edges later.
   task automatic run_table(input int ch);
      int n;
      vec_t v;
      n = (ch == 0) ? v0.size() : v1.size();
      for (int i = 0; i <= n; i++) begin
         if (ch == 0) begin
            bus0.sym_in = (i < n) ? v0[i].sym : TOK00;
            bus1.sym_in = TOK00;
         end else begin
            bus1.sym_in = (i < n) ? v1[i].sym : TOK00;
            bus0.sym_in = TOK00;
         end
         @(posedge clk); #1;
         if (i >= 1) begin
            v = (ch == 0) ? v0[i-1] : v1[i-1];
            check($sformatf("ch%0d row%0d", ch, i-1), (ch == 0) ? outs0() : outs1(), packv(v));
         end
      end
   endtask

   initial begin
      int off;
      bit found;

      // channel 0: control, illegal, video guard + video decode, aborted guard
      v0.push_back(mk(TOK00,   2'd0, 1'b0, 8'h00, 2'b00, 1'b0, 4'h0, 1'b0));
      v0.push_back(mk(10'h000, 2'd0, 1'b0, 8'h00, 2'b00, 1'b0, 4'h0, 1'b1));
      v0.push_back(mk(TOK01,   2'd0, 1'b0, 8'h00, 2'b01, 1'b0, 4'h0, 1'b0));
      v0.push_back(mk(VG0,     2'd3, 1'b0, 8'h00, 2'b00, 1'b0, 4'h0, 1'b0));
      v0.push_back(mk(VG0,     2'd3, 1'b0, 8'h00, 2'b00, 1'b0, 4'h0, 1'b0));
      v0.push_back(mk(10'h0FF, 2'd1, 1'b1, 8'hFF, 2'b00, 1'b0, 4'h0, 1'b0));
      v0.push_back(mk(10'h100, 2'd1, 1'b1, 8'h00, 2'b00, 1'b0, 4'h0, 1'b0));
      v0.push_back(mk(10'h200, 2'd1, 1'b1, 8'hFF, 2'b00, 1'b0, 4'h0, 1'b0));
      v0.push_back(mk(10'h355, 2'd1, 1'b1, 8'hFE, 2'b00, 1'b0, 4'h0, 1'b0));
      v0.push_back(mk(10'h10F, 2'd1, 1'b1, 8'h11, 2'b00, 1'b0, 4'h0, 1'b0));
      v0.push_back(mk(TOK10,   2'd0, 1'b0, 8'h00, 2'b10, 1'b0, 4'h0, 1'b0));
      v0.push_back(mk(TOK11,   2'd0, 1'b0, 8'h00, 2'b11, 1'b0, 4'h0, 1'b0));
      v0.push_back(mk(VG0,     2'd3, 1'b0, 8'h00, 2'b00, 1'b0, 4'h0, 1'b0));
      v0.push_back(mk(10'h000, 2'd0, 1'b0, 8'h00, 2'b00, 1'b0, 4'h0, 1'b1));
      v0.push_back(mk(TOK00,   2'd0, 1'b0, 8'h00, 2'b00, 1'b0, 4'h0, 1'b0));

      // channel 1: islands with trailing guards, illegal in island, ambiguous guard into video
      v1.push_back(mk(TOK00,   2'd0, 1'b0, 8'h00, 2'b00, 1'b0, 4'h0, 1'b0));
      v1.push_back(mk(GD1,     2'd3, 1'b0, 8'h00, 2'b00, 1'b0, 4'h0, 1'b0));
      v1.push_back(mk(GD1,     2'd3, 1'b0, 8'h00, 2'b00, 1'b0, 4'h0, 1'b0));
      v1.push_back(mk(10'h29C, 2'd2, 1'b0, 8'h00, 2'b00, 1'b1, 4'h0, 1'b0));
      v1.push_back(mk(10'h2C3, 2'd2, 1'b0, 8'h00, 2'b00, 1'b1, 4'hF, 1'b0));
      v1.push_back(mk(GD1,     2'd3, 1'b0, 8'h00, 2'b00, 1'b0, 4'h0, 1'b0));
      v1.push_back(mk(GD1,     2'd3, 1'b0, 8'h00, 2'b00, 1'b0, 4'h0, 1'b0));
      v1.push_back(mk(TOK00,   2'd0, 1'b0, 8'h00, 2'b00, 1'b0, 4'h0, 1'b0));
      v1.push_back(mk(GD1,     2'd3, 1'b0, 8'h00, 2'b00, 1'b0, 4'h0, 1'b0));
      v1.push_back(mk(GD1,     2'd3, 1'b0, 8'h00, 2'b00, 1'b0, 4'h0, 1'b0));
      v1.push_back(mk(10'h19C, 2'd2, 1'b0, 8'h00, 2'b00, 1'b1, 4'hA, 1'b0));
      v1.push_back(mk(10'h000, 2'd2, 1'b0, 8'h00, 2'b00, 1'b0, 4'h0, 1'b1));
      v1.push_back(mk(10'h11E, 2'd2, 1'b0, 8'h00, 2'b00, 1'b1, 4'h5, 1'b0));
      v1.push_back(mk(GD1,     2'd3, 1'b0, 8'h00, 2'b00, 1'b0, 4'h0, 1'b0));
      v1.push_back(mk(GD1,     2'd3, 1'b0, 8'h00, 2'b00, 1'b0, 4'h0, 1'b0));
      v1.push_back(mk(TOK11,   2'd0, 1'b0, 8'h00, 2'b11, 1'b0, 4'h0, 1'b0));
      v1.push_back(mk(GD1,     2'd3, 1'b0, 8'h00, 2'b00, 1'b0, 4'h0, 1'b0));
      v1.push_back(mk(GD1,     2'd3, 1'b0, 8'h00, 2'b00, 1'b0, 4'h0, 1'b0));
      v1.push_back(mk(10'h100, 2'd1, 1'b1, 8'h00, 2'b00, 1'b0, 4'h0, 1'b0));
      v1.push_back(mk(10'h355, 2'd1, 1'b1, 8'hFE, 2'b00, 1'b0, 4'h0, 1'b0));
      v1.push_back(mk(TOK00,   2'd0, 1'b0, 8'h00, 2'b00, 1'b0, 4'h0, 1'b0));

      // Reset state
      bus0.sym_in = TOK00;
      bus1.sym_in = TOK00;
      #22;
      check("reset ch0", {outs0()[18:0], bus0.bitslip, bus0.slip_count, bus0.locked}, 32'd0);
      check("reset ch1", {outs1()[18:0], bus1.bitslip, bus1.slip_count, bus1.locked}, 32'd0);
      rst_n = 1'b1;

      // Aligned token stream: lock after CTRL_RUN tokens plus pipeline delay
      repeat (CTRL_RUN) @(posedge clk);
      #1;
      check("lock not early", {31'd0, bus0.locked}, 32'd0);
      @(posedge clk); #1;
      check("lock ch0", {31'd0, bus0.locked}, 32'd1);
      check("lock ch1", {31'd0, bus1.locked}, 32'd1);
      check("ctrl 00", {30'd0, bus0.ctrl}, 32'd0);
      repeat (8) @(posedge clk);
      #1;

      run_table(0);
      run_table(1);
      check("lock kept ch0", {31'd0, bus0.locked}, 32'd1);
      check("lock kept ch1", {31'd0, bus1.locked}, 32'd1);
      check("no bitslip while locked", slip_seen, 32'd0);

      // Watchdog: LOSS_CYCLES symbols without a control token drop lock
      for (int n = 1; n <= LOSS_CYCLES + 1; n++) begin
         bus0.sym_in = (n <= 2) ? VG0 : 10'h100;
         @(posedge clk); #1;
         if (n == LOSS_CYCLES) check("locked before expiry", {30'd0, bus0.locked, bus0.de}, 32'd3);
         if (n == LOSS_CYCLES + 1) check("lock lost", {28'd0, bus0.locked, bus0.period, bus0.de}, 32'd0);
      end

      // Search resumes; reset asynchronously in the middle of the slip pulse
      found = 1'b0;
      for (int n = 0; n < SEARCH_CYCLES + 100; n++) begin
         @(posedge clk); #1;
         if (bus0.bitslip) begin
            found = 1'b1;
            break;
         end
      end
      check("slip after loss", {31'd0, found}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("reset mid-slip", {outs0()[18:0], bus0.bitslip, bus0.slip_count, bus0.locked}, 32'd0);

      // Rotated by 3 bits: bench deserialiser rotates once per bitslip pulse
      off = 0;
      bus0.sym_in = rotl(TOK00, 3);
      #20;
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 8 * (SEARCH_CYCLES + 20); n++) begin
         @(posedge clk); #1;
         if (bus0.bitslip) off++;
         if (bus0.locked) break;
         bus0.sym_in = rotl(TOK00, (3 + off) % 10);
      end
      check("rot lock", {31'd0, bus0.locked}, 32'd1);
      check("rot slips", off, 32'd7);
      check("rot slip_count", {28'd0, bus0.slip_count}, 32'd7);
      repeat (20) @(posedge clk);
      #1;
      check("rot stays", {27'd0, bus0.locked, bus0.slip_count}, 32'h17);
      check("rot ctrl", {28'd0, bus0.period, bus0.ctrl}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
